// File: rtl/matrix_memory_pkg.sv
// matrix_memory_pkg
// Shared sizing constants, element type and the flat-address helper for
// the matrix_memory block. Storage is NUM_MAT matrices of DIM x DIM
// elements laid out matrix-major, then row-major.
package matrix_memory_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_MAT = 4;
    localparam int DIM     = 3;
    localparam int SEL_W   = 2;
    localparam int IDX_W   = 2;

    localparam int DEPTH  = NUM_MAT * DIM * DIM;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] elem_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } flat_addr_t;

    // Flat address plus legality. The address is only meaningful when
    // valid is set; callers must gate every access with valid.
    function automatic flat_addr_t calc_flat_addr(
        input logic [SEL_W-1:0] sel,
        input logic [IDX_W-1:0] row,
        input logic [IDX_W-1:0] col
    );
        flat_addr_t result;
        int         flat;
        result.valid = (int'(sel) < NUM_MAT) && (int'(row) < DIM) && (int'(col) < DIM);
        flat         = (int'(sel) * DIM + int'(row)) * DIM + int'(col);
        result.addr  = result.valid ? ADDR_W'(flat) : '0;
        return result;
    endfunction

endpackage

// File: rtl/matrix_memory_addr.sv
// matrix_memory_addr
// Combinational decode of (matrix_select, row, col) into a flat storage
// address and a legality flag.
// Ports:
//   matrix_select - matrix index
//   row, col      - element indices
//   addr          - flat address (0 when illegal)
//   valid         - 1 when all indices are in range
module matrix_memory_addr
    import matrix_memory_pkg::*;
(
    input  logic [SEL_W-1:0]  matrix_select,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);

    flat_addr_t decoded;

    always_comb begin
        decoded = calc_flat_addr(matrix_select, row, col);
        addr    = decoded.addr;
        valid   = decoded.valid;
    end

endmodule

// File: rtl/matrix_memory.sv
// matrix_memory
// Storage for NUM_MAT square DIM x DIM matrices of DATA_W-bit elements.
// Synchronous writes, registered reads with one-cycle latency, and a
// synchronous active-low reset that clears every entry and read_data.
// Because reset must clear the whole array in one edge, storage is a
// register array rather than a block RAM.
// Ports:
//   clk           - system clock, rising edge
//   reset         - synchronous active-low reset
//   matrix_select - matrix index
//   row, col      - element indices
//   write_enable  - store write_data at the addressed element
//   read_enable   - capture the addressed element into read_data
//   write_data    - data to store
//   read_data     - registered read result (0 for illegal addresses)
// Build option:
//   MATRIX_MEMORY_BYPASS_EN - a read and write in the same cycle return
//   write_data (write-first). Default is read-before-write.
module matrix_memory
    import matrix_memory_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  matrix_select,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    elem_t             mem_reg [DEPTH];
    logic [DEPTH-1:0]  entry_we;
    elem_t             read_data_reg;
    elem_t             read_data_next;

    matrix_memory_addr u_addr (
        .matrix_select (matrix_select),
        .row           (row),
        .col           (col),
        .addr          (addr),
        .valid         (addr_valid)
    );

    // One-hot write strobe per entry; illegal addresses strobe nothing.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = write_enable && addr_valid && (addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                mem_reg[i] <= '0;
            end else if (entry_we[i]) begin
                mem_reg[i] <= write_data;
            end
        end
    end

    // Read and write share one address, so a simultaneous access is
    // always a same-address collision.
    always_comb begin
        read_data_next = read_data_reg;
        if (read_enable) begin
            if (!addr_valid) begin
                read_data_next = '0;
            end else begin
`ifdef MATRIX_MEMORY_BYPASS_EN
                read_data_next = write_enable ? write_data : mem_reg[addr];
`else
                read_data_next = mem_reg[addr];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_data_reg <= '0;
        end else begin
            read_data_reg <= read_data_next;
        end
    end

    assign read_data = read_data_reg;

endmodule

// File: tb/tb_matrix_memory.sv
// tb_matrix_memory
// Directed test-plan sequences followed by random traffic, each cycle
// checked against a 3-D array model of the matrices.
module tb_matrix_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] matrix_select;
    logic [1:0] row;
    logic [1:0] col;
    logic       write_enable;
    logic       read_enable;
    logic [7:0] write_data;
    logic [7:0] read_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [4][3][3];
    logic [7:0] exp_rd;

    always #5 clk = ~clk;

    matrix_memory dut (
        .clk           (clk),
        .reset         (reset),
        .matrix_select (matrix_select),
        .row           (row),
        .col           (col),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .write_data    (write_data),
        .read_data     (read_data)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock transaction: drive, clock, update model, compare.
    task automatic step(input string tag, input logic rst_n, input logic [1:0] s,
                        input logic [1:0] r, input logic [1:0] c,
                        input logic we, input logic re, input logic [7:0] wd);
        logic legal;
        reset         = rst_n;
        matrix_select = s;
        row           = r;
        col           = c;
        write_enable  = we;
        read_enable   = re;
        write_data    = wd;
        @(posedge clk);
        legal = (s < 2'd3 || s == 2'd3) && (r < 2'd3) && (c < 2'd3);
        if (!rst_n) begin
            for (int m = 0; m < 4; m++)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        model_mem[m][i][j] = 8'h00;
            exp_rd = 8'h00;
        end else begin
            if (re) begin
                if (!legal) exp_rd = 8'h00;
`ifdef MATRIX_MEMORY_BYPASS_EN
                else if (we) exp_rd = wd;
`endif
                else exp_rd = model_mem[s][r][c];
            end
            if (we && legal) model_mem[s][r][c] = wd;
        end
        #1;
        $display("%-10s rst=%b m=%0d r=%0d c=%0d we=%b re=%b wd=%h rd=%h exp=%h",
                 tag, rst_n, s, r, c, we, re, wd, read_data, exp_rd);
        check(tag, read_data, exp_rd);
    endtask

    task automatic read_matrix(input string tag, input logic [1:0] s);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                step(tag, 1'b1, s, 2'(i), 2'(j), 1'b0, 1'b1, 8'h00);
    endtask

    task automatic fill_matrix0();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                step("fill", 1'b1, 2'd0, 2'(i), 2'(j), 1'b1, 1'b0, 8'(i * 3 + j + 1));
    endtask

    initial begin
        exp_rd = 8'h00;
        // Reset for two cycles, then every entry reads zero.
        step("reset", 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h77);
        step("reset", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00);
        check("rst_rd", read_data, 8'h00);
        for (int m = 0; m < 4; m++) read_matrix("rst_scan", 2'(m));

        // Fill matrix 0 with 1..9 and read back.
        fill_matrix0();
        step("rd00", 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00);
        check("fill_00", read_data, 8'd1);
        step("rd11", 1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 1'b1, 8'h00);
        check("fill_11", read_data, 8'd5);
        step("rd22", 1'b1, 2'd0, 2'd2, 2'd2, 1'b0, 1'b1, 8'h00);
        check("fill_22", read_data, 8'd9);
        read_matrix("fill_scan", 2'd0);

        // Isolation between matrices.
        step("iso_wr", 1'b1, 2'd1, 2'd1, 2'd2, 1'b1, 1'b0, 8'hA5);
        step("iso_m0", 1'b1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 8'h00);
        check("iso_m0_12", read_data, 8'd6);
        step("iso_m1", 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1, 8'h00);
        check("iso_m1_12", read_data, 8'hA5);
        step("iso_m2", 1'b1, 2'd2, 2'd1, 2'd2, 1'b0, 1'b1, 8'h00);
        check("iso_m2_12", read_data, 8'h00);

        // Illegal row/col writes change nothing; illegal reads give 0.
        step("ill_wr", 1'b1, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0, 8'hFF);
        step("ill_wr", 1'b1, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 8'hFF);
        step("pre_ill", 1'b1, 2'd0, 2'd2, 2'd2, 1'b0, 1'b1, 8'h00);
        step("ill_rd", 1'b1, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1, 8'h00);
        check("ill_rd_row3", read_data, 8'h00);
        step("rd00", 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00);
        check("ill_keep_00", read_data, 8'd1);
        for (int m = 0; m < 4; m++) read_matrix("ill_scan", 2'(m));

        // Hold for three cycles with read_enable low.
        step("rd11", 1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step("hold", 1'b1, 2'(k), 2'd0, 2'd0, 1'b0, 1'b0, 8'h00);
            check("hold_val", read_data, 8'd5);
        end

        // Same-address read+write collision.
        step("collide", 1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'd42);
`ifdef MATRIX_MEMORY_BYPASS_EN
        check("collide_rd", read_data, 8'd42);
`else
        check("collide_rd", read_data, 8'd1);
`endif
        step("post_col", 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00);
        check("collide_new", read_data, 8'd42);

        // Reset in the middle of operation discards data.
        fill_matrix0();
        step("rd22", 1'b1, 2'd0, 2'd2, 2'd2, 1'b0, 1'b1, 8'h00);
        step("mid_rst", 1'b0, 2'd0, 2'd2, 2'd2, 1'b1, 1'b1, 8'h33);
        check("mid_rst_rd", read_data, 8'h00);
        read_matrix("mid_scan", 2'd0);
        step("mid_m1", 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1, 8'h00);
        check("mid_m1_12", read_data, 8'h00);

        // Random traffic, including illegal indices and occasional reset.
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_memory.md
Name: matrix_memory

Overview:
Small on-chip storage for up to four square matrices of 8-bit elements, addressed by matrix index, row and column. It is used by the matrix datapath to load operands element-by-element and read them back. Writes are synchronous. Reads are registered with one-cycle latency.

Parameters:
DATA_W, 8, element width in bits
NUM_MAT, 4, number of matrices stored (must be <= 2**SEL_W)
DIM, 3, matrix dimension (DIM x DIM elements); legal row/col indices are 0..DIM-1
SEL_W, 2, width of matrix_select
IDX_W, 2, width of row and col (DIM must be <= 2**IDX_W)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
matrix_select  input  SEL_W  matrix index for the current access
row  input  IDX_W  element row index
col  input  IDX_W  element column index
write_enable  input  1  write write_data to the addressed element this cycle
read_enable  input  1  capture the addressed element into read_data this cycle
write_data  input  DATA_W  data to store
read_data  output  DATA_W  registered read result

Behaviour:
- Storage: NUM_MAT*DIM*DIM entries of DATA_W bits.
  - Flat address = (matrix_select*DIM + row)*DIM + col, computed only for legal indices.
- Reset: evaluated on a clk rising edge while reset==0.
  - All storage entries clear to 0; read_data clears to 0.
  - Reset has priority over write_enable and read_enable.
  - A reset asserted mid-sequence discards all previously written data.
- Write: on a rising edge with reset==1 and write_enable==1, mem[addr] <= write_data.
- Read: on a rising edge with reset==1 and read_enable==1, read_data <= mem[addr].
  - Value is visible after that edge, i.e. one-cycle latency.
- read_enable==0: read_data holds its previous value.
- Illegal address (matrix_select >= NUM_MAT, row >= DIM, or col >= DIM):
  - write is ignored; no entry changes;
  - read loads read_data with 0.
- Simultaneous read and write to the same address: read_data gets the OLD stored value (read-before-write), unless the optional feature is enabled.
- Simultaneous read and write to different addresses: both complete independently.
- Inputs are sampled only at rising edges; no combinational path from inputs to read_data.

Optional Feature:
MATRIX_MEMORY_BYPASS_EN
- Defined: when read_enable and write_enable are both 1 in the same cycle with the same legal address, read_data <= write_data (write-first forwarding). The stored value updates as normal.
- Undefined: read-before-write as specified above.

Decomposition:
- Package matrix_memory_pkg holds:
  - DATA_W, DIM, NUM_MAT, SEL_W, IDX_W defaults;
  - an element typedef (logic [DATA_W-1:0]);
  - a function computing flat address and legality from sel/row/col.
- One natural sub-module, matrix_memory_addr: combinational address decode producing flat address plus a valid flag. Storage array and read register stay in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read [0][0][0] with read_enable=1 -> read_data=0 one cycle later; every entry reads 0.
- Fill and readback: write matrix 0 row-major with 1..9 at [r][c] (one element per cycle), then read each -> [0][0]=1, [1][1]=5, [2][2]=9, each one cycle after the read is issued.
- Isolation: write matrix 1 [1][2]=8'hA5, matrix 0 filled with 1..9 -> matrix 0 [1][2] still reads 6, matrix 1 [1][2] reads 8'hA5, matrix 2 [1][2] reads 0.
- Illegal index: write row=3,col=0,data=8'hFF on matrix 0 -> no entry changes; reading row=3 gives read_data=0; reading [0][0] still gives 1.
- Hold and same-address collision:
  - read_enable=0 -> read_data holds last value for 3 cycles;
  - read+write [0][0] with data 8'd42 in one cycle -> read_data=1 (bypass off) or 42 (MATRIX_MEMORY_BYPASS_EN); next read -> 42.
- Reset mid-operation: after filling matrix 0, assert reset=0 for one edge -> read_data=0 and all of matrix 0 reads 0 afterwards.
